// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI engine among several requesters
//
// Ports:
//   clk, reset          system clock (also clocks the engine), async active-high reset
//   req                 per-requester request level, held until ack
//   req_data            per-requester outgoing word, slice i = [32*i+31:32*i]
//   req_write_bits      per-requester write bit count, slice i = [6*i+5:6*i]
//   req_read_bits       per-requester read bit count, slice i = [6*i+5:6*i]
//   ack                 one-cycle completion pulse to the served requester
//   rd_data             read data of the last completed transaction
//   err                 pulses with ack when the transaction was rejected or timed out
//   grant_idx           index of the current or last winner
//   spi_data_out        engine data_out (stable from grant to next grant)
//   spi_write_bits      engine write_bits
//   spi_read_bits       engine read_bits
//   spi_request_action  engine request_action, one-cycle start strobe
//   spi_busy            engine busy
//   spi_data_in         engine data_in, valid in the cycle busy falls
module spi_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_W       = 3,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [6*NUM_REQ-1:0]  req_write_bits,
    input  logic [6*NUM_REQ-1:0]  req_read_bits,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rd_data,
    output logic                  err,
    output logic [GRANT_W-1:0]    grant_idx,
    output logic [31:0]           spi_data_out,
    output logic [5:0]            spi_write_bits,
    output logic [5:0]            spi_read_bits,
    output logic                  spi_request_action,
    input  logic                  spi_busy,
    input  logic [31:0]           spi_data_in
);
    // Requester tables are padded to a power of two so a GRANT_W-bit index
    // addresses them exactly; padding slots never request.
    localparam int SLOTS = 1 << GRANT_W;
    localparam int TW    = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SLOTS-1:0] req_pad;
    logic [31:0]      data_arr  [SLOTS];
    logic [5:0]       wbits_arr [SLOTS];
    logic [5:0]       rbits_arr [SLOTS];

    for (genvar i = 0; i < SLOTS; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_real
            assign req_pad[i]   = req[i];
            assign data_arr[i]  = req_data[32*i +: 32];
            assign wbits_arr[i] = req_write_bits[6*i +: 6];
            assign rbits_arr[i] = req_read_bits[6*i +: 6];
        end else begin : g_pad
            assign req_pad[i]   = 1'b0;
            assign data_arr[i]  = 32'h0;
            assign wbits_arr[i] = 6'h0;
            assign rbits_arr[i] = 6'h0;
        end
    end

    logic [GRANT_W-1:0] ptr;
    logic               reject;
    logic [TW-1:0]      tmo_cnt;

    logic [GRANT_W-1:0] cand_idx;
    logic [GRANT_W-1:0] win_idx;
    logic               win_found;

    logic               do_grant;
    logic               do_capture;
    logic               set_reject;

    // Round-robin search starting just above the last winner, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = GRANT_W'((int'(ptr) + k) % NUM_REQ);
            if (!win_found && req_pad[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next         = state;
        do_grant           = 1'b0;
        do_capture         = 1'b0;
        set_reject         = 1'b0;
        spi_request_action = 1'b0;
        ack                = '0;
        err                = 1'b0;
        case (state)
            IDLE: begin
                // A busy engine here means someone else started it; wait it out.
                if (win_found && !spi_busy) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Rejected grants pass through here with the strobe suppressed,
                // so every grant spends one cycle before its outcome is decided.
                if (reject) begin
                    state_next = DONE;
                end else begin
                    spi_request_action = 1'b1;
                    state_next         = WAIT_START;
                end
            end
            WAIT_START: begin
                if (spi_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == '0) begin
                    set_reject = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    do_capture = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ack        = NUM_REQ'(1) << grant_idx;
                err        = reject;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= GRANT_W'(NUM_REQ - 1);
            grant_idx      <= '0;
            spi_data_out   <= '0;
            spi_write_bits <= '0;
            spi_read_bits  <= '0;
            rd_data        <= '0;
            reject         <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            state <= state_next;

            if (do_grant) begin
                grant_idx      <= win_idx;
                ptr            <= win_idx;
                spi_data_out   <= data_arr[win_idx];
                spi_write_bits <= wbits_arr[win_idx];
                spi_read_bits  <= rbits_arr[win_idx];
                reject         <= (wbits_arr[win_idx] > 6'd32) || (rbits_arr[win_idx] > 6'd32);
            end else if (set_reject) begin
                reject <= 1'b1;
            end else if (state == DONE) begin
                reject <= 1'b0;
            end

            if (state == ISSUE) begin
                tmo_cnt <= TW'(START_TIMEOUT);
            end else if (state == WAIT_START && !spi_busy && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end

            if (do_capture) begin
                rd_data <= spi_data_in;
            end
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - scoreboard testbench for spi_arbiter with a behavioural SPI engine
module tb_spi_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int GRANT_W       = 3;
    localparam int START_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req;
    logic [31:0]           d_arr    [NUM_REQ];
    logic [5:0]            wb_arr   [NUM_REQ];
    logic [5:0]            rb_arr   [NUM_REQ];
    logic [31:0]           resp_mem [NUM_REQ];
    logic [32*NUM_REQ-1:0] req_data;
    logic [6*NUM_REQ-1:0]  req_write_bits;
    logic [6*NUM_REQ-1:0]  req_read_bits;

    logic [NUM_REQ-1:0] ack;
    logic [31:0]        rd_data;
    logic               err;
    logic [GRANT_W-1:0] grant_idx;
    logic [31:0]        spi_data_out;
    logic [5:0]         spi_write_bits;
    logic [5:0]         spi_read_bits;
    logic               spi_request_action;

    logic        eng_busy;
    logic        eng_en;
    logic [31:0] eng_data;
    logic [31:0] eng_rsp;
    int          eng_cnt;

    always_comb begin
        req_data       = '0;
        req_write_bits = '0;
        req_read_bits  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[32*i +: 32]      = d_arr[i];
            req_write_bits[6*i +: 6]  = wb_arr[i];
            req_read_bits[6*i +: 6]   = rb_arr[i];
        end
    end

    spi_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .GRANT_W       (GRANT_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (rst),
        .req                (req),
        .req_data           (req_data),
        .req_write_bits     (req_write_bits),
        .req_read_bits      (req_read_bits),
        .ack                (ack),
        .rd_data            (rd_data),
        .err                (err),
        .grant_idx          (grant_idx),
        .spi_data_out       (spi_data_out),
        .spi_write_bits     (spi_write_bits),
        .spi_read_bits      (spi_read_bits),
        .spi_request_action (spi_request_action),
        .spi_busy           (eng_busy),
        .spi_data_in        (eng_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rmask(input logic [5:0] rb);
        if (rb >= 6'd32) return 32'hFFFF_FFFF;
        return (32'h1 << rb) - 32'h1;
    endfunction

    function automatic int dur(input logic [5:0] wb, input logic [5:0] rb);
        int s;
        s = int'(wb) + int'(rb);
        return (s == 0) ? 1 : 1 + s / 16;
    endfunction

    // Engine stub: goes busy the cycle after the strobe, data valid when busy falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            eng_data <= 32'h0;
            eng_rsp  <= 32'h0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_data <= eng_rsp;
            end
        end else if (spi_request_action && eng_en) begin
            eng_busy <= 1'b1;
            eng_cnt  <= dur(spi_write_bits, spi_read_bits);
            eng_rsp  <= resp_mem[grant_idx[1:0]] & rmask(spi_read_bits);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        err;
        int          kind;   // 1: latency from strobe, 2: latency from req raise
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd = 32'h0;
    int          act_cnt = 0;
    int          ack_cnt = 0;
    int          busy_cnt = 0;
    int          last_act = 0;
    int          req_mark = 0;
    int          hold_acks = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (eng_busy) busy_cnt++;
            if (spi_request_action) begin
                act_cnt++;
                last_act = cyc;
                check("act_vs_busy", {31'h0, eng_busy}, 32'h0);
            end
            if (err && ack == '0) check("err_without_ack", {31'h0, err}, 32'h0);
            if (ack != '0) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", {28'h0, ack}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack_onehot", {28'h0, ack}, 32'h1 << e.idx);
                    check("grant_idx", {29'h0, grant_idx}, e.idx);
                    check("err", {31'h0, err}, {31'h0, e.err});
                    check("rd_data", rd_data, e.rd);
                    if (e.kind == 1) check("lat_from_act", cyc - last_act, e.lat);
                    else if (e.kind == 2) check("lat_from_req", cyc - req_mark, e.lat);
                end
                if (hold_acks > 0) begin
                    hold_acks--;
                    if (hold_acks == 0) req = '0;
                end else begin
                    req = req & ~ack;
                end
            end
        end
    end

    task automatic setup(input int idx, input logic [31:0] data, input logic [5:0] wb,
                         input logic [5:0] rb, input logic [31:0] rsp);
        d_arr[idx]    = data;
        wb_arr[idx]   = wb;
        rb_arr[idx]   = rb;
        resp_mem[idx] = rsp;
    endtask

    task automatic push(input int idx, input logic tmo, input int kind, input int lat);
        exp_t e;
        e.idx  = idx;
        e.kind = kind;
        e.lat  = lat;
        if (wb_arr[idx] > 6'd32 || rb_arr[idx] > 6'd32 || tmo) begin
            e.err = 1'b1;
            e.rd  = model_rd;
        end else begin
            e.err    = 1'b0;
            e.rd     = resp_mem[idx] & rmask(rb_arr[idx]);
            model_rd = e.rd;
        end
        sb.push_back(e);
    endtask

    task automatic raise(input logic [NUM_REQ-1:0] m);
        req_mark = cyc;
        req      = m;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {28'h0, ack}, 32'h0);
        check({tag, "_rd"}, rd_data, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
        check({tag, "_gidx"}, {29'h0, grant_idx}, 32'h0);
        check({tag, "_dout"}, spi_data_out, 32'h0);
        check({tag, "_wbits"}, {26'h0, spi_write_bits}, 32'h0);
        check({tag, "_rbits"}, {26'h0, spi_read_bits}, 32'h0);
        check({tag, "_act"}, {31'h0, spi_request_action}, 32'h0);
    endtask

    initial begin
        int a0;
        int b0;
        int n;
        req    = '0;
        eng_en = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) setup(i, 32'h0, 6'd0, 6'd0, 32'h0);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Round-robin from reset: all four held for eight transactions.
        for (int i = 0; i < NUM_REQ; i++) setup(i, 32'hA000_0000 + i, 6'd8, 6'd8, 32'h1234_5600 + 32'(i * 17));
        for (int k = 0; k < 8; k++) push(k % 4, 1'b0, 1, 4);
        a0 = ack_cnt;
        hold_acks = 8;
        raise(4'b1111);
        drain(200);
        check("rr_ack_count", ack_cnt - a0, 8);

        // Single request on requester 2.
        setup(2, 32'h0000_80A5, 6'd16, 6'd8, 32'h0000_003C);
        push(2, 1'b0, 1, 4);
        a0 = act_cnt;
        raise(4'b0100);
        drain(50);
        check("single_act_count", act_cnt - a0, 1);
        check("single_dout", spi_data_out, 32'h0000_80A5);

        // Reject on oversize write count; then pointer must sit at 1.
        setup(1, 32'hDEAD_BEEF, 6'd33, 6'd8, 32'h5555_5555);
        push(1, 1'b0, 2, 2);
        a0 = act_cnt;
        raise(4'b0010);
        drain(50);
        check("reject_act_count", act_cnt - a0, 0);
        setup(0, 32'h0000_0011, 6'd8, 6'd8, 32'h0000_0077);
        setup(2, 32'h0000_0022, 6'd8, 6'd8, 32'h0000_0088);
        push(2, 1'b0, 1, 4);
        push(0, 1'b0, 1, 4);
        raise(4'b0101);
        drain(100);

        // Timeout with a dead engine, then normal service once it recovers.
        eng_en = 1'b0;
        setup(3, 32'h0000_0033, 6'd8, 6'd8, 32'h0000_0099);
        push(3, 1'b1, 1, START_TIMEOUT + 2);
        raise(4'b1000);
        drain(50);
        eng_en = 1'b1;
        push(0, 1'b0, 1, 4);
        raise(4'b0001);
        drain(50);

        // Zero-length transaction.
        setup(1, 32'h0000_0000, 6'd0, 6'd0, 32'hFFFF_FFFF);
        push(1, 1'b0, 1, 3);
        b0 = busy_cnt;
        raise(4'b0010);
        drain(50);
        check("zero_busy_cycles", busy_cnt - b0, 1);

        // Reset while the engine is mid-transfer.
        setup(1, 32'hCAFE_F00D, 6'd32, 6'd32, 32'h0BAD_0BAD);
        push(1, 1'b0, 1, 7);
        raise(4'b0010);
        n = 0;
        while (!eng_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_busy_seen", {31'h0, eng_busy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        sb.delete();
        model_rd = 32'h0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_engine_idle", {31'h0, eng_busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        push(0, 1'b0, 1, 4);
        push(2, 1'b0, 1, 4);
        raise(4'b0101);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
